mem_wb_stage: RTL and testbench

//  Memory-access stage plus MEM/WB pipeline register of the five-stage MIPS core. Takes ALU results

---
 rtl/mem_wb_stage_if.sv | 28 ++
 rtl/mem_wb_stage.sv | 219 +++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory port of the MEM/WB stage.
//   dm_req   : request, held until dm_ack
//   dm_we    : 1 store, 0 load
//   dm_addr  : word-aligned byte address
//   dm_be    : byte enables, bit n = byte n (little-endian)
//   dm_wdata : lane-replicated store data
//   dm_ack   : memory completes the request this cycle
//   dm_rdata : load word, valid with dm_ack
// master = pipeline stage, slave = data memory.
interface mem_wb_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register of the five-stage MIPS core.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ex_*                : instruction presented by EX (valid, GPR write info, result/address,
//                         memory op, store data)
//   stall_req           : EX must hold its outputs while a memory access is outstanding
//   dm                  : data-memory req/ack port (master side)
//   wb_wr_en/addr/data  : register file write port, one registered stage after MEM
//   align_err, bus_err  : one-cycle pulses for a dropped misaligned access / timeout abort
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_wreg,
    input  logic [4:0]            ex_waddr,
    input  logic [31:0]           ex_result,
    input  logic [3:0]            ex_mem_op,
    input  logic [31:0]           ex_st_data,
    output logic                  stall_req,
    mem_wb_stage_if.master        dm,
    output logic                  wb_wr_en,
    output logic [4:0]            wb_wr_addr,
    output logic [31:0]           wb_wr_data,
    output logic                  align_err,
    output logic                  bus_err
);
    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    localparam int unsigned CntW = 10;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic            dm_req_q, dm_req_d;
    logic            dm_we_q, dm_we_d;
    logic [31:0]     dm_addr_q, dm_addr_d;
    logic [3:0]      dm_be_q, dm_be_d;
    logic [31:0]     dm_wdata_q, dm_wdata_d;
    logic [3:0]      op_q, op_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      waddr_q, waddr_d;
    logic            wreg_q, wreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wb_wr_en_q, wb_wr_en_d;
    logic [4:0]      wb_wr_addr_q, wb_wr_addr_d;
    logic [31:0]     wb_wr_data_q, wb_wr_data_d;
    logic            align_err_q, align_err_d;
    logic            bus_err_q, bus_err_d;

    logic            is_load, is_store, misaligned;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;

    // Decode of the incoming op; 9-15 fall through as NONE.
    always_comb begin
        is_load    = (ex_mem_op >= OpLb) && (ex_mem_op <= OpLw);
        is_store   = (ex_mem_op >= OpSb) && (ex_mem_op <= OpSw);
        misaligned = 1'b0;
        if (ex_mem_op == OpLh || ex_mem_op == OpLhu || ex_mem_op == OpSh) begin
            misaligned = ex_result[0];
        end else if (ex_mem_op == OpLw || ex_mem_op == OpSw) begin
            misaligned = (ex_result[1:0] != 2'b00);
        end
    end

    // Lane extraction of the returning load word using the captured op and offset.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dm.dm_rdata[7:0];
            2'd1:    ld_byte = dm.dm_rdata[15:8];
            2'd2:    ld_byte = dm.dm_rdata[23:16];
            default: ld_byte = dm.dm_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        case (op_q)
            OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_data = {24'h0, ld_byte};
            OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_data = {16'h0, ld_half};
            default: ld_data = dm.dm_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dm_req_d     = dm_req_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_be_d      = dm_be_q;
        dm_wdata_d   = dm_wdata_q;
        op_d         = op_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        wreg_d       = wreg_q;
        cnt_d        = cnt_q;
        wb_wr_en_d   = 1'b0;
        wb_wr_addr_d = wb_wr_addr_q;
        wb_wr_data_d = wb_wr_data_q;
        align_err_d  = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (is_load || is_store) begin
                        if (misaligned) begin
                            align_err_d = 1'b1;
                        end else begin
                            state_d   = StBusy;
                            dm_req_d  = 1'b1;
                            dm_we_d   = is_store;
                            dm_addr_d = {ex_result[31:2], 2'b00};
                            op_d      = ex_mem_op;
                            off_d     = ex_result[1:0];
                            waddr_d   = ex_waddr;
                            wreg_d    = ex_wreg;
                            cnt_d     = '0;
                            // Enables sized by access width so loads advertise their lanes too.
                            if (ex_mem_op == OpLb || ex_mem_op == OpLbu || ex_mem_op == OpSb) begin
                                dm_be_d    = 4'b0001 << ex_result[1:0];
                                dm_wdata_d = {4{ex_st_data[7:0]}};
                            end else if (ex_mem_op == OpLh || ex_mem_op == OpLhu ||
                                         ex_mem_op == OpSh) begin
                                dm_be_d    = 4'b0011 << ex_result[1:0];
                                dm_wdata_d = {2{ex_st_data[15:0]}};
                            end else begin
                                dm_be_d    = 4'hF;
                                dm_wdata_d = ex_st_data;
                            end
                        end
                    end else if (ex_wreg && (ex_waddr != 5'd0)) begin
                        wb_wr_en_d   = 1'b1;
                        wb_wr_addr_d = ex_waddr;
                        wb_wr_data_d = ex_result;
                    end
                end
            end
            default: begin
                // Ack on the final counted cycle takes priority over the timeout.
                if (dm.dm_ack) begin
                    state_d  = StIdle;
                    dm_req_d = 1'b0;
                    if (!dm_we_q && wreg_q && (waddr_q != 5'd0)) begin
                        wb_wr_en_d   = 1'b1;
                        wb_wr_addr_d = waddr_q;
                        wb_wr_data_d = ld_data;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    dm_req_d  = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_be_q      <= '0;
            dm_wdata_q   <= '0;
            op_q         <= '0;
            off_q        <= '0;
            waddr_q      <= '0;
            wreg_q       <= 1'b0;
            cnt_q        <= '0;
            wb_wr_en_q   <= 1'b0;
            wb_wr_addr_q <= '0;
            wb_wr_data_q <= '0;
            align_err_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dm_req_q     <= dm_req_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_be_q      <= dm_be_d;
            dm_wdata_q   <= dm_wdata_d;
            op_q         <= op_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            wreg_q       <= wreg_d;
            cnt_q        <= cnt_d;
            wb_wr_en_q   <= wb_wr_en_d;
            wb_wr_addr_q <= wb_wr_addr_d;
            wb_wr_data_q <= wb_wr_data_d;
            align_err_q  <= align_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall_req   = (state_q == StBusy);
    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_be    = dm_be_q;
    assign dm.dm_wdata = dm_wdata_q;
    assign wb_wr_en    = wb_wr_en_q;
    assign wb_wr_addr  = wb_wr_addr_q;
    assign wb_wr_data  = wb_wr_data_q;
    assign align_err   = align_err_q;
    assign bus_err     = bus_err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a transaction-level reference model.
module tb_mem_wb_stage;
    localparam int unsigned TO = 8;

    localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4;
    localparam logic [3:0] LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_wreg;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_result, ex_st_data;
    logic [3:0]  ex_mem_op;
    logic        stall_req, wb_wr_en, align_err, bus_err;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the register-file write port's held address/data.
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    mem_wb_stage_if dmi ();

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_wreg    (ex_wreg),
        .ex_waddr   (ex_waddr),
        .ex_result  (ex_result),
        .ex_mem_op  (ex_mem_op),
        .ex_st_data (ex_st_data),
        .stall_req  (stall_req),
        .dm         (dmi),
        .wb_wr_en   (wb_wr_en),
        .wb_wr_addr (wb_wr_addr),
        .wb_wr_data (wb_wr_data),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ld_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    task automatic check_wb_hold();
        check("wb_addr", 32'(wb_wr_addr), 32'(exp_addr));
        check("wb_data", wb_wr_data, exp_data);
    endtask

    task automatic idle_cycle();
        ex_valid  = 1'b0;
        ex_mem_op = 4'($urandom);
        @(posedge clk); #1;
        check("idle_wb_en", 32'(wb_wr_en), 0);
        check("idle_stall", 32'(stall_req), 0);
        check("idle_bus_err", 32'(bus_err), 0);
        check_wb_hold();
    endtask

    // delay: number of BUSY cycles without ack before ack; >= TO means no ack.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic wreg, input logic [4:0] wa, input int delay,
                          input logic [31:0] rd);
        bit is_ld, is_st, mis, done;
        logic [31:0] be_exp, wd_exp;
        is_ld = (op >= 1) && (op <= 5);
        is_st = (op >= 6) && (op <= 8);
        mis = ((op == LH || op == LHU || op == SH) && (addr % 2 != 0)) ||
              ((op == LW || op == SW) && (addr % 4 != 0));
        ex_valid = 1'b1; ex_mem_op = op; ex_result = addr; ex_st_data = sd;
        ex_wreg = wreg; ex_waddr = wa;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_op = 4'($urandom); ex_result = $urandom;
        if (!is_ld && !is_st) begin
            if (wreg && wa != 0) begin
                exp_addr = wa; exp_data = addr;
                check("alu_wb_en", 32'(wb_wr_en), 1);
            end else begin
                check("alu_wb_en", 32'(wb_wr_en), 0);
            end
            check_wb_hold();
            check("alu_stall", 32'(stall_req), 0);
            check("alu_dm_req", 32'(dmi.dm_req), 0);
        end else if (mis) begin
            check("mis_align_err", 32'(align_err), 1);
            check("mis_dm_req", 32'(dmi.dm_req), 0);
            check("mis_stall", 32'(stall_req), 0);
            check("mis_wb_en", 32'(wb_wr_en), 0);
            @(posedge clk); #1;
            check("mis_align_pulse", 32'(align_err), 0);
            check("mis_dm_req2", 32'(dmi.dm_req), 0);
        end else begin
            check("mem_dm_we", 32'(dmi.dm_we), 32'(is_st));
            check("mem_dm_addr", dmi.dm_addr, addr & 32'hFFFF_FFFC);
            if (is_st) begin
                case (op)
                    SB: begin be_exp = 1 << (addr % 4); wd_exp = (sd & 32'hFF) * 32'h0101_0101; end
                    SH: begin be_exp = 3 << (addr % 4); wd_exp = (sd & 32'hFFFF) * 32'h0001_0001; end
                    default: begin be_exp = 15; wd_exp = sd; end
                endcase
                check("st_dm_be", 32'(dmi.dm_be), be_exp);
                check("st_dm_wdata", dmi.dm_wdata, wd_exp);
            end
            done = 1'b0;
            for (int i = 0; i < int'(TO) && !done; i++) begin
                check("busy_stall", 32'(stall_req), 1);
                check("busy_dm_req", 32'(dmi.dm_req), 1);
                check("busy_dm_addr", dmi.dm_addr, addr & 32'hFFFF_FFFC);
                if (i == delay) begin dmi.dm_ack = 1'b1; dmi.dm_rdata = rd; end
                else begin dmi.dm_ack = 1'b0; dmi.dm_rdata = $urandom; end
                @(posedge clk); #1;
                dmi.dm_ack = 1'b0;
                if (i == delay) begin
                    done = 1'b1;
                    check("ack_dm_req", 32'(dmi.dm_req), 0);
                    check("ack_stall", 32'(stall_req), 0);
                    check("ack_bus_err", 32'(bus_err), 0);
                    if (is_ld && wreg && wa != 0) begin
                        exp_addr = wa; exp_data = ld_ref(op, addr, rd);
                        check("ld_wb_en", 32'(wb_wr_en), 1);
                    end else begin
                        check("ack_wb_en", 32'(wb_wr_en), 0);
                    end
                    check_wb_hold();
                end else if (i == int'(TO) - 1) begin
                    done = 1'b1;
                    check("to_bus_err", 32'(bus_err), 1);
                    check("to_dm_req", 32'(dmi.dm_req), 0);
                    check("to_stall", 32'(stall_req), 0);
                    check("to_wb_en", 32'(wb_wr_en), 0);
                end else begin
                    check("busy_wb_en", 32'(wb_wr_en), 0);
                    check("busy_bus_err", 32'(bus_err), 0);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_wreg = 1'b0; ex_waddr = '0; ex_result = '0;
        ex_mem_op = '0; ex_st_data = '0; dmi.dm_ack = 1'b0; dmi.dm_rdata = '0;
        exp_addr = '0; exp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_en", 32'(wb_wr_en), 0);
        check("rst_dm_req", 32'(dmi.dm_req), 0);
        check("rst_stall", 32'(stall_req), 0);
        check("rst_align", 32'(align_err), 0);
        check("rst_bus", 32'(bus_err), 0);
        check_wb_hold();
        reset = 1'b0;
        idle_cycle();

        // Directed scenarios.
        run_op(NONE, 32'h1234_5678, 0, 1'b1, 5'd5, 0, 0);
        check("t1_data", wb_wr_data, 32'h1234_5678);
        run_op(LB, 32'h103, 0, 1'b1, 5'd7, 2, 32'h80FF_0000);
        check("t2_lb", wb_wr_data, 32'hFFFF_FF80);
        run_op(LBU, 32'h103, 0, 1'b1, 5'd7, 2, 32'h80FF_0000);
        check("t2_lbu", wb_wr_data, 32'h0000_0080);
        run_op(SH, 32'h202, 32'hAAAA_BEEF, 1'b0, 5'd0, 1, 0);
        run_op(LW, 32'h101, 0, 1'b1, 5'd9, 0, 0);
        run_op(NONE, 32'hDEAD_BEEF, 0, 1'b1, 5'd0, 0, 0);
        run_op(LW, 32'h400, 0, 1'b1, 5'd3, int'(TO), 0);
        run_op(NONE, 32'h0BAD_F00D, 0, 1'b1, 5'd4, 0, 0);
        run_op(LH, 32'h402, 0, 1'b1, 5'd6, int'(TO) - 1, 32'h8001_7FFF);
        idle_cycle();

        // Reset while BUSY, then a late ack in IDLE.
        ex_valid = 1'b1; ex_mem_op = LW; ex_result = 32'h800; ex_wreg = 1'b1; ex_waddr = 5'd8;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("r_busy_stall", 32'(stall_req), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_addr = '0; exp_data = '0;
        check("r_dm_req", 32'(dmi.dm_req), 0);
        check("r_stall", 32'(stall_req), 0);
        check("r_wb_en", 32'(wb_wr_en), 0);
        check_wb_hold();
        dmi.dm_ack = 1'b1; dmi.dm_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmi.dm_ack = 1'b0;
        check("late_ack_wb_en", 32'(wb_wr_en), 0);
        check("late_ack_dm_req", 32'(dmi.dm_req), 0);
        check("late_ack_stall", 32'(stall_req), 0);
        check_wb_hold();

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 3)) &
                                                (($urandom_range(0, 1) != 0) ? 32'h0 : 32'h3);
            run_op(op, a, $urandom, 1'($urandom), 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, TO)), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
